// File: rtl/cm_sketch_ctrl.sv
// cm_sketch_ctrl: front-end controller for the count-min sketch pipeline.
// Round-robin arbitrates NUM_REQ requesters onto the single sketch update
// port and manages epochs. An epoch ends after EPOCH_LEN updates or on a
// flush. The block then drains the pipeline and sweeps a clear over all W rows.
// Optional statistics counters are enabled with the macro CM_SKETCH_CTRL_STATS_EN.
module cm_sketch_ctrl #(
    parameter int NUM_REQ   = 4,
    parameter int W         = 4096,
    parameter int HASH_SIZE = $clog2(W),
    parameter int ADDR_SIZE = 22,
    parameter int EPOCH_LEN = 65536,
    parameter int PIPE_LAT  = 8,
    parameter int CNT_W     = 32
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_REQ-1:0]           req_valid,
    input  logic [NUM_REQ*ADDR_SIZE-1:0] req_addr,
    output logic [NUM_REQ-1:0]           req_ready,
    input  logic                         flush_req,
    output logic                         sk_valid,
    output logic [ADDR_SIZE-1:0]         sk_addr,
    output logic                         clr_valid,
    output logic [HASH_SIZE-1:0]         clr_idx,
    output logic                         busy,
    output logic                         epoch_done
`ifdef CM_SKETCH_CTRL_STATS_EN
    ,
    output logic [CNT_W-1:0]             stat_accepted,
    output logic [CNT_W-1:0]             stat_epochs
`endif
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int EC_W  = (EPOCH_LEN > 1) ? $clog2(EPOCH_LEN + 1) : 1;
    localparam int DC_W  = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        CLEAR = 2'd2
    } state_t;

    state_t               state;
    logic [PTR_W-1:0]     rr_ptr;
    logic [EC_W-1:0]      epoch_cnt;
    logic [DC_W-1:0]      drain_cnt;

    logic                 grant_any;
    logic [PTR_W-1:0]     next_ptr;
    logic [ADDR_SIZE-1:0] sel_addr;
    logic [EC_W-1:0]      epoch_inc;
    logic                 limit_hit;
    logic                 sweep_done;

    // Round-robin search starting at rr_ptr; only the winner sees ready, and only in RUN
    always_comb begin
        int               cand;
        logic [PTR_W-1:0] cand_ptr;
        grant_any = 1'b0;
        next_ptr  = '0;
        sel_addr  = '0;
        req_ready = '0;
        cand      = 0;
        cand_ptr  = '0;
        if (state == RUN) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                cand = int'(rr_ptr) + i;
                if (cand >= NUM_REQ) begin
                    cand = cand - NUM_REQ;
                end
                cand_ptr = PTR_W'(cand);
                if (!grant_any && req_valid[cand_ptr]) begin
                    grant_any           = 1'b1;
                    req_ready[cand_ptr] = 1'b1;
                    sel_addr            = ADDR_SIZE'(req_addr >> (cand * ADDR_SIZE));
                    next_ptr            = (cand == NUM_REQ - 1) ? '0 : PTR_W'(cand + 1);
                end
            end
        end
    end

    assign epoch_inc  = epoch_cnt + EC_W'(1);
    assign limit_hit  = (EPOCH_LEN != 0) && grant_any && (epoch_inc == EC_W'(EPOCH_LEN));
    assign sweep_done = (state == CLEAR) && clr_valid && (clr_idx == HASH_SIZE'(W - 1));

    // Epoch FSM: forwards granted updates, drains in-flight work, then sweeps the clear
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= CLEAR;
            rr_ptr     <= '0;
            epoch_cnt  <= '0;
            drain_cnt  <= '0;
            sk_valid   <= 1'b0;
            sk_addr    <= '0;
            clr_valid  <= 1'b0;
            clr_idx    <= '0;
            busy       <= 1'b0;
            epoch_done <= 1'b0;
        end else begin
            sk_valid   <= 1'b0;
            sk_addr    <= '0;
            epoch_done <= 1'b0;
            case (state)
                RUN: begin
                    clr_valid <= 1'b0;
                    if (grant_any) begin
                        sk_valid  <= 1'b1;
                        sk_addr   <= sel_addr;
                        rr_ptr    <= next_ptr;
                        epoch_cnt <= epoch_inc;
                    end
                    if (flush_req || limit_hit) begin
                        state     <= DRAIN;
                        busy      <= 1'b1;
                        drain_cnt <= '0;
                    end
                end
                DRAIN: begin
                    busy <= 1'b1;
                    if (drain_cnt == DC_W'(PIPE_LAT - 1)) begin
                        state     <= CLEAR;
                        clr_valid <= 1'b1;
                        clr_idx   <= '0;
                    end else begin
                        drain_cnt <= drain_cnt + DC_W'(1);
                    end
                end
                CLEAR: begin
                    busy <= 1'b1;
                    if (!clr_valid) begin
                        // Coming out of reset clr_idx is already 0, so this is the row-0 strobe
                        clr_valid <= 1'b1;
                    end else if (sweep_done) begin
                        clr_valid  <= 1'b0;
                        clr_idx    <= '0;
                        epoch_done <= 1'b1;
                        epoch_cnt  <= '0;
                        busy       <= 1'b0;
                        state      <= RUN;
                    end else begin
                        clr_idx <= clr_idx + HASH_SIZE'(1);
                    end
                end
                default: begin
                    state <= CLEAR;
                end
            endcase
        end
    end

`ifdef CM_SKETCH_CTRL_STATS_EN
    // Lifetime statistics, saturating, untouched by epoch boundaries
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_accepted <= '0;
            stat_epochs   <= '0;
        end else begin
            if (grant_any && (stat_accepted != {CNT_W{1'b1}})) begin
                stat_accepted <= stat_accepted + CNT_W'(1);
            end
            if (sweep_done && (stat_epochs != {CNT_W{1'b1}})) begin
                stat_epochs <= stat_epochs + CNT_W'(1);
            end
        end
    end
`endif

endmodule

// File: tb/tb_cm_sketch_ctrl.sv
// Self-checking bench for cm_sketch_ctrl with W=16, PIPE_LAT=4, EPOCH_LEN=10.
// A behavioural model is stepped alongside the DUT and compared every cycle;
// directed sections pin the model with hand-computed expectations.
module tb_cm_sketch_ctrl;

    localparam int NR = 4;
    localparam int WW = 16;
    localparam int HS = 4;
    localparam int AS = 22;
    localparam int EL = 10;
    localparam int PL = 4;
    localparam int CW = 32;

    logic            clk = 1'b0;
    logic            rst;
    logic [NR-1:0]   req_valid;
    logic [NR*AS-1:0] req_addr;
    logic [NR-1:0]   req_ready;
    logic            flush_req;
    logic            sk_valid;
    logic [AS-1:0]   sk_addr;
    logic            clr_valid;
    logic [HS-1:0]   clr_idx;
    logic            busy;
    logic            epoch_done;
`ifdef CM_SKETCH_CTRL_STATS_EN
    logic [CW-1:0]   stat_accepted;
    logic [CW-1:0]   stat_epochs;
`endif

    cm_sketch_ctrl #(
        .NUM_REQ(NR), .W(WW), .HASH_SIZE(HS), .ADDR_SIZE(AS),
        .EPOCH_LEN(EL), .PIPE_LAT(PL), .CNT_W(CW)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_addr(req_addr), .req_ready(req_ready),
        .flush_req(flush_req),
        .sk_valid(sk_valid), .sk_addr(sk_addr),
        .clr_valid(clr_valid), .clr_idx(clr_idx),
        .busy(busy), .epoch_done(epoch_done)
`ifdef CM_SKETCH_CTRL_STATS_EN
        , .stat_accepted(stat_accepted), .stat_epochs(stat_epochs)
`endif
    );

    // Free-running clock
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Behavioural model state: phase 0 = accepting, 1 = draining, 2 = clearing
    int            m_phase;
    int            m_rr;
    int            m_epoch;
    int            m_drain_left;
    int            m_clr_pos;
    logic          e_sk_valid;
    logic [AS-1:0] e_sk_addr;
    logic          e_clr_valid;
    int            e_clr_idx;
    logic          e_busy;
    logic          e_done;
    logic [CW-1:0] m_acc;
    logic [CW-1:0] m_eps;

    // Observations captured mid-cycle
    logic [AS-1:0] cur_addr [NR];
    logic [NR-1:0] obs_ready;
    logic          obs_sk;
    logic [AS-1:0] obs_sk_addr;
    logic          obs_clr;
    logic [HS-1:0] obs_clr_idx;
    logic          obs_busy;
    logic          obs_done;
    logic [CW-1:0] obs_acc;
    logic [CW-1:0] obs_eps;
    int            cnt_sk;
    int            cnt_busy;
    int            cnt_clr;

    function automatic int pickGrant(input logic [NR-1:0] v, input int ptr);
        for (int k = 0; k < NR; k++) begin
            int p;
            p = (ptr + k) % NR;
            if (v[p]) return p;
        end
        return -1;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%0h expected=0x%0h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic modelReset();
        m_phase      = 2;
        m_rr         = 0;
        m_epoch      = 0;
        m_drain_left = 0;
        m_clr_pos    = 0;
        e_sk_valid   = 1'b0;
        e_sk_addr    = '0;
        e_clr_valid  = 1'b0;
        e_clr_idx    = 0;
        e_busy       = 1'b0;
        e_done       = 1'b0;
        m_acc        = '0;
        m_eps        = '0;
    endtask

    // One clock edge of the model, using the inputs held during the cycle
    task automatic modelStep();
        int g;
        e_done     = 1'b0;
        e_sk_valid = 1'b0;
        e_sk_addr  = '0;
        if (m_phase == 0) begin
            e_clr_valid = 1'b0;
            g = pickGrant(req_valid, m_rr);
            if (g >= 0) begin
                e_sk_valid = 1'b1;
                e_sk_addr  = req_addr[g*AS +: AS];
                m_rr       = (g + 1) % NR;
                m_epoch    = m_epoch + 1;
                if (m_acc != {CW{1'b1}}) m_acc = m_acc + 1;
            end
            if (flush_req || (EL != 0 && g >= 0 && m_epoch == EL)) begin
                m_phase      = 1;
                m_drain_left = PL;
                e_busy       = 1'b1;
            end
        end else if (m_phase == 1) begin
            m_drain_left = m_drain_left - 1;
            if (m_drain_left == 0) begin
                m_phase     = 2;
                e_clr_valid = 1'b1;
                e_clr_idx   = 0;
                m_clr_pos   = 1;
            end
        end else begin
            e_busy = 1'b1;
            if (m_clr_pos < WW) begin
                e_clr_valid = 1'b1;
                e_clr_idx   = m_clr_pos;
                m_clr_pos   = m_clr_pos + 1;
            end else begin
                e_clr_valid = 1'b0;
                e_done      = 1'b1;
                e_busy      = 1'b0;
                m_epoch     = 0;
                m_phase     = 0;
                if (m_eps != {CW{1'b1}}) m_eps = m_eps + 1;
            end
        end
    endtask

    task automatic compareModel();
        logic [NR-1:0] er;
        int g;
        er = '0;
        if (m_phase == 0) begin
            g = pickGrant(req_valid, m_rr);
            if (g >= 0) er = NR'(1) << g;
        end
        checkOutput("req_ready", 64'(req_ready), 64'(er));
        checkOutput("sk_valid", 64'(sk_valid), 64'(e_sk_valid));
        checkOutput("sk_addr", 64'(sk_addr), 64'(e_sk_addr));
        checkOutput("clr_valid", 64'(clr_valid), 64'(e_clr_valid));
        if (e_clr_valid || rst) begin
            checkOutput("clr_idx", 64'(clr_idx), 64'(e_clr_idx));
        end
        checkOutput("busy", 64'(busy), 64'(e_busy));
        checkOutput("epoch_done", 64'(epoch_done), 64'(e_done));
        checkOutput("sk_clr_overlap", 64'(sk_valid & clr_valid), 64'(0));
`ifdef CM_SKETCH_CTRL_STATS_EN
        checkOutput("stat_accepted", 64'(stat_accepted), 64'(m_acc));
        checkOutput("stat_epochs", 64'(stat_epochs), 64'(m_eps));
`endif
    endtask

    // Drive one cycle of inputs, compare at the falling edge, then step the model on the rising edge
    task automatic applyStimulus(input logic [NR-1:0] v, input logic f, input logic r);
        req_valid = v;
        flush_req = f;
        rst       = r;
        for (int p = 0; p < NR; p++) begin
            cur_addr[p] = AS'($urandom);
            req_addr[p*AS +: AS] = cur_addr[p];
        end
        if (r) modelReset();
        @(negedge clk);
        compareModel();
        obs_ready   = req_ready;
        obs_sk      = sk_valid;
        obs_sk_addr = sk_addr;
        obs_clr     = clr_valid;
        obs_clr_idx = clr_idx;
        obs_busy    = busy;
        obs_done    = epoch_done;
`ifdef CM_SKETCH_CTRL_STATS_EN
        obs_acc     = stat_accepted;
        obs_eps     = stat_epochs;
`else
        obs_acc     = '0;
        obs_eps     = '0;
`endif
        if (sk_valid) cnt_sk++;
        if (busy) cnt_busy++;
        if (clr_valid) cnt_clr++;
        @(posedge clk);
        if (rst) modelReset();
        else modelStep();
        #1;
    endtask

    task automatic runUntilDone(input logic [NR-1:0] v, input int flush_at, input int budget, output int n_cyc);
        int   c;
        logic done;
        c    = 0;
        done = 1'b0;
        while (!done && c < budget) begin
            c++;
            applyStimulus(v, (c == flush_at), 1'b0);
            done = obs_done;
        end
        n_cyc = c;
        if (!done) checkOutput("epoch_done_timeout", 64'(0), 64'(1));
    endtask

    initial begin
        logic [NR-1:0] exp_seq [3];
        logic [AS-1:0] saved_addr;
        logic [NR-1:0] ready_or;
        logic          done_or;
        int            n_cyc;
        logic          found;

        exp_seq[0] = 4'b0010;
        exp_seq[1] = 4'b0100;
        exp_seq[2] = 4'b1000;
        req_valid = '0;
        req_addr  = '0;
        flush_req = 1'b0;
        rst       = 1'b1;
        modelReset();

        // Reset state
        for (int i = 0; i < 3; i++) applyStimulus('0, 1'b0, 1'b1);
        checkOutput("reset_clr_valid", 64'(obs_clr), 64'(0));
        checkOutput("reset_busy", 64'(obs_busy), 64'(0));
        checkOutput("reset_sk_valid", 64'(obs_sk), 64'(0));
        checkOutput("reset_ready", 64'(obs_ready), 64'(0));

        // Release: no strobe before the first edge, then 16 strobes with all requesters waiting
        applyStimulus(4'hF, 1'b0, 1'b0);
        checkOutput("release_no_strobe_yet", 64'(obs_clr), 64'(0));
        cnt_clr  = 0;
        ready_or = '0;
        done_or  = 1'b0;
        for (int k = 1; k <= WW; k++) begin
            applyStimulus(4'hF, 1'b0, 1'b0);
            ready_or |= obs_ready;
            done_or  |= obs_done;
            if (k == 1)  checkOutput("first_clr_idx", 64'(obs_clr_idx), 64'(0));
            if (k == WW) checkOutput("last_clr_idx", 64'(obs_clr_idx), 64'(WW - 1));
        end
        checkOutput("reset_sweep_strobes", 64'(cnt_clr), 64'(WW));
        checkOutput("ready_during_sweep", 64'(ready_or), 64'(0));
        checkOutput("done_during_sweep", 64'(done_or), 64'(0));

        // Sweep completion cycle: epoch_done and the first grant goes to port 0
        applyStimulus(4'hF, 1'b0, 1'b0);
        checkOutput("reset_epoch_done", 64'(obs_done), 64'(1));
        checkOutput("grant_port0", 64'(obs_ready), 64'(4'b0001));
        cnt_sk = 0;
        for (int k = 0; k < 3; k++) begin
            applyStimulus(4'hF, 1'b0, 1'b0);
            checkOutput("grant_rotation", 64'(obs_ready), 64'(exp_seq[k]));
        end
        saved_addr = cur_addr[3];

        // Only port 2 requesting, then everybody: next grant must be port 3
        for (int k = 0; k < 3; k++) begin
            applyStimulus(4'b0100, 1'b0, 1'b0);
            checkOutput("grant_only_port2", 64'(obs_ready), 64'(4'b0100));
            if (k == 0) checkOutput("sk_addr_port3", 64'(obs_sk_addr), 64'(saved_addr));
        end
        applyStimulus(4'hF, 1'b0, 1'b0);
        checkOutput("grant_after_port2", 64'(obs_ready), 64'(4'b1000));

        // Epoch limit: two more handshakes reach 10, then 4 drain + 16 clear cycles
        cnt_busy = 0;
        cnt_clr  = 0;
        runUntilDone(4'hF, 0, 100, n_cyc);
        checkOutput("epoch_sk_pulses", 64'(cnt_sk), 64'(EL));
        checkOutput("epoch_busy_cycles", 64'(cnt_busy), 64'(PL + WW));
        checkOutput("epoch_clr_strobes", 64'(cnt_clr), 64'(WW));
        checkOutput("epoch_cycles_to_done", 64'(n_cyc), 64'(23));
`ifdef CM_SKETCH_CTRL_STATS_EN
        checkOutput("stat_accepted_epoch1", 64'(obs_acc), 64'(10));
        checkOutput("stat_epochs_epoch1", 64'(obs_eps), 64'(2));
`endif

        // Flush coinciding with the handshake at epoch count 5
        for (int k = 0; k < 4; k++) applyStimulus(4'hF, 1'b0, 1'b0);
        applyStimulus(4'hF, 1'b1, 1'b0);
        checkOutput("flush_cycle_grant", 64'(obs_ready), 64'(4'b1000));
        saved_addr = cur_addr[3];
        applyStimulus('0, 1'b0, 1'b0);
        checkOutput("flush_update_forwarded", 64'(obs_sk), 64'(1));
        checkOutput("flush_update_addr", 64'(obs_sk_addr), 64'(saved_addr));
        checkOutput("flush_enters_drain", 64'(obs_busy), 64'(1));
        cnt_busy = 0;
        cnt_clr  = 0;
        runUntilDone('0, 9, 100, n_cyc);
        checkOutput("flush_busy_cycles", 64'(cnt_busy), 64'(PL + WW - 1));
        checkOutput("flush_in_clear_ignored", 64'(cnt_clr), 64'(WW));
        checkOutput("flush_cycles_to_done", 64'(n_cyc), 64'(20));
`ifdef CM_SKETCH_CTRL_STATS_EN
        checkOutput("stat_accepted_flush", 64'(obs_acc), 64'(16));
        checkOutput("stat_epochs_flush", 64'(obs_eps), 64'(3));
`endif

        // Randomized traffic with occasional flushes and resets
        for (int k = 0; k < 1500; k++) begin
            applyStimulus(NR'($urandom_range(0, 15)),
                          ($urandom_range(0, 63) == 0),
                          ($urandom_range(0, 499) == 0));
        end

        // Reset in the middle of a sweep at row 7
        found = 1'b0;
        for (int k = 0; k < 300 && !found; k++) begin
            applyStimulus(NR'($urandom_range(0, 15)), 1'b1, 1'b0);
            if (obs_clr && obs_clr_idx == HS'(7)) found = 1'b1;
        end
        checkOutput("found_clr_idx7", 64'(found), 64'(1));
        applyStimulus('0, 1'b0, 1'b1);
        applyStimulus('0, 1'b0, 1'b1);
        checkOutput("midclear_rst_clr_valid", 64'(obs_clr), 64'(0));
        checkOutput("midclear_rst_busy", 64'(obs_busy), 64'(0));
`ifdef CM_SKETCH_CTRL_STATS_EN
        checkOutput("midclear_rst_accepted", 64'(obs_acc), 64'(0));
        checkOutput("midclear_rst_epochs", 64'(obs_eps), 64'(0));
`endif
        applyStimulus('0, 1'b0, 1'b0);
        applyStimulus(4'hF, 1'b0, 1'b0);
        checkOutput("restart_clr_valid", 64'(obs_clr), 64'(1));
        checkOutput("restart_clr_idx", 64'(obs_clr_idx), 64'(0));
        cnt_clr = 0;
        runUntilDone(4'hF, 0, 100, n_cyc);
        checkOutput("restart_remaining_strobes", 64'(cnt_clr), 64'(WW - 1));
        checkOutput("restart_cycles_to_done", 64'(n_cyc), 64'(WW));

        for (int k = 0; k < 40; k++) applyStimulus(NR'($urandom_range(0, 15)), 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cm_sketch_ctrl.md
Name: cm_sketch_ctrl

Overview:
Front-end controller for the count-min sketch pipeline. It round-robin arbitrates NUM_REQ address requesters onto the single sketch update port and manages sketch epochs. An epoch ends after EPOCH_LEN accepted updates or on a flush request. At epoch end the block drains the sketch pipeline, then sweeps a clear over all W counter rows before accepting new traffic.

Parameters:
NUM_REQ, 4, number of requester ports (1..16)
W, 4096, sketch width (rows to clear per hash)
HASH_SIZE, $clog2(W), clear index width
ADDR_SIZE, 22, address width
EPOCH_LEN, 65536, accepted updates per epoch; 0 disables the automatic epoch end
PIPE_LAT, 8, cycles to drain in-flight sketch updates before clearing
CNT_W, 32, statistics counter width

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-high
req_valid  in  NUM_REQ  per-requester request valid
req_addr  in  NUM_REQ*ADDR_SIZE  per-requester address; port i occupies bits [i*ADDR_SIZE +: ADDR_SIZE]
req_ready  out  NUM_REQ  per-requester accept; combinational
flush_req  in  1  single-cycle pulse that ends the epoch early
sk_valid  out  1  update valid to the sketch, registered
sk_addr  out  ADDR_SIZE  update address to the sketch, registered
clr_valid  out  1  clear-row strobe to the sketch, registered
clr_idx  out  HASH_SIZE  row being cleared, registered
busy  out  1  high in DRAIN or CLEAR
epoch_done  out  1  one-cycle pulse when a clear sweep completes

Behaviour:
- States: RUN, DRAIN, CLEAR.
- Reset: state=CLEAR, clr_idx=0, rr_ptr=0, epoch_cnt=0, drain_cnt=0. All outputs 0 during reset.
- After reset release, the first clear strobe (idx 0) appears on the first clk edge, so the sketch is initialised before any traffic.
- Arbitration (RUN only):
  - The grant goes to the lowest-index valid requester at or above rr_ptr, wrapping around.
  - req_ready[g]=1 only for the granted port. All other ready bits are 0.
  - At most one handshake per cycle.
  - On a handshake, rr_ptr <= (g+1) mod NUM_REQ. With no handshake, rr_ptr holds.
- Update path: a handshake in cycle t gives sk_valid=1 and sk_addr=req_addr[g] in cycle t+1. Otherwise sk_valid=0 and sk_addr=0.
- Epoch counting: each handshake increments epoch_cnt.
  - If EPOCH_LEN!=0 and the increment reaches EPOCH_LEN, go to DRAIN next cycle.
  - If flush_req is sampled in RUN, go to DRAIN next cycle.
  - A handshake in the same cycle as flush_req or the limit is still forwarded and counted.
- DRAIN:
  - All req_ready=0.
  - Lasts exactly PIPE_LAT cycles (drain_cnt counts from 0 to PIPE_LAT-1), then go to CLEAR with clr_idx=0.
- CLEAR:
  - All req_ready=0.
  - clr_valid=1 with clr_idx=0,1,...,W-1 on consecutive cycles, exactly W strobes.
  - The cycle after the strobe for idx W-1: clr_valid=0, epoch_done=1 for one cycle, epoch_cnt=0, state=RUN.
  - rr_ptr is preserved across the epoch boundary.
- busy = (state!=RUN). It is registered together with the state.
- flush_req in DRAIN or CLEAR is ignored and not queued.
- clr_valid and sk_valid are never high in the same cycle.
- Asserting rst mid-DRAIN or mid-CLEAR aborts immediately. The block restarts a full clear from idx 0 after release.

Optional Feature:
Macro CM_SKETCH_CTRL_STATS_EN.
- Defined: adds outputs stat_accepted[CNT_W] and stat_epochs[CNT_W].
  - stat_accepted counts all handshakes since reset.
  - stat_epochs counts epoch_done pulses.
  - Both saturate at all-ones, reset to 0, and are not cleared by an epoch end.
- Not defined: the ports and counters do not exist. All other behaviour is identical.

Test Plan:
- Reset release with W=16, PIPE_LAT=4 -> clr_idx 0..15 on 16 consecutive cycles, epoch_done the next cycle, req_ready all 0 until then.
- All 4 req_valid held high in RUN, rr_ptr=0 -> grants 0,1,2,3,0,... one per cycle; sk_addr matches each granted address one cycle later.
- Only req_valid[2] high for 3 cycles -> 3 handshakes on port 2; then all 4 high -> the next grant is port 3.
- EPOCH_LEN=10 with continuous traffic -> exactly 10 sk_valid pulses, then busy=1, 4 idle DRAIN cycles, 16 clr strobes, epoch_done, traffic resumes.
- flush_req coincident with a handshake at epoch_cnt=5 -> that update is forwarded; DRAIN follows. A second flush_req during CLEAR -> no extra sweep.
- With STATS_EN: 2 full epochs of EPOCH_LEN=10 -> stat_accepted=20, stat_epochs=3 (including the reset sweep). Assert rst mid-CLEAR at idx 7 -> counters reset to 0 and the sweep restarts at idx 0.
